// File: rtl/rvvi_buffer.sv
// First-word-fall-through elastic buffer between the RVVI trace compressor and the
// Ethernet packetizer. Each head record is stamped with a running frame count.
module rvvi_buffer #(
    parameter int unsigned RVVI_WIDTH        = 632,
    parameter int unsigned DEPTH             = 16,
    parameter int unsigned FRAME_COUNT_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [RVVI_WIDTH-1:0]         InRvvi,
    input  logic                          InValid,
    output logic                          InStall,
    output logic [RVVI_WIDTH-1:0]         OutRvvi,
    output logic                          OutValid,
    input  logic                          OutStall,
    output logic [FRAME_COUNT_WIDTH-1:0]  FrameCount,
    output logic [$clog2(DEPTH):0]        Level,
    output logic                          Overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [RVVI_WIDTH-1:0]        r_mem [DEPTH];
    logic [PW-1:0]                r_wr_ptr;
    logic [PW-1:0]                r_rd_ptr;
    logic [FRAME_COUNT_WIDTH-1:0] r_frame_count;
    logic                         r_overflow;

    logic [PW-1:0] w_level;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    // Occupancy comes only from registered pointers; the extra wrap bit separates full from empty.
    always_comb begin
        w_level = r_wr_ptr - r_rd_ptr;
        w_full  = (w_level == PW'(DEPTH));
        w_empty = (w_level == '0);
        w_push  = InValid & ~w_full;
        w_pop   = ~w_empty & ~OutStall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_frame_count <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr      <= r_rd_ptr + PW'(1);
                r_frame_count <= r_frame_count + FRAME_COUNT_WIDTH'(1);
            end
            if (InValid & w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= InRvvi;
        end
    end

    always_comb begin
        InStall    = w_full;
        OutValid   = ~w_empty;
        OutRvvi    = r_mem[r_rd_ptr[AW-1:0]];
        FrameCount = r_frame_count;
        Level      = w_level;
        Overflow   = r_overflow;
    end

endmodule

// File: tb/tb_rvvi_buffer.sv
// Directed-vector bench for rvvi_buffer: table of single-cycle vectors plus
// hand-written sequences for fill, wrap, reset and packetizer-style draining.
module tb_rvvi_buffer;

    localparam int unsigned RW    = 632;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned FW    = 64;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] in_rvvi;
    logic          in_valid;
    logic          in_stall;
    logic [RW-1:0] out_rvvi;
    logic          out_valid;
    logic          out_stall;
    logic [FW-1:0] frame_count;
    logic [LW-1:0] level;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned     q[$];
    int unsigned     cur_tag;
    longint unsigned m_fc;
    bit              m_ovf;

    always #5 clk = ~clk;

    rvvi_buffer #(
        .RVVI_WIDTH(RW), .DEPTH(DEPTH), .FRAME_COUNT_WIDTH(FW)
    ) dut (
        .clk(clk), .reset(reset),
        .InRvvi(in_rvvi), .InValid(in_valid), .InStall(in_stall),
        .OutRvvi(out_rvvi), .OutValid(out_valid), .OutStall(out_stall),
        .FrameCount(frame_count), .Level(level), .Overflow(overflow)
    );

    function automatic logic [RW-1:0] rec(input int unsigned tag);
        logic [639:0] w;
        w = {20{tag ^ 32'hA5A5_0000}};
        return w[RW-1:0];
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_data(input string name, input logic [RW-1:0] act, input int unsigned tag);
        logic [RW-1:0] exp;
        exp = rec(tag);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got low word %0h, expected %0h (tag %0d, t=%0t)",
                     name, act[63:0], exp[63:0], tag, $time);
        end
    endtask

    task automatic drive(input bit v, input int unsigned tag, input bit stall);
        in_valid  = v;
        cur_tag   = tag;
        in_rvvi   = rec(tag);
        out_stall = stall;
    endtask

    // One clock with a behavioural queue model checking head before and state after the edge.
    task automatic tick();
        bit pop_m;
        bit push_m;
        bit full_m;
        if (!reset) begin
            if (q.size() > 0) begin
                check("head_valid", longint'(out_valid), 1);
                check_data("head_data", out_rvvi, q[0]);
                check("head_fc", frame_count, m_fc);
            end else begin
                check("empty_valid", longint'(out_valid), 0);
            end
        end
        full_m = (q.size() == DEPTH);
        pop_m  = (q.size() > 0) && !out_stall;
        push_m = in_valid && !full_m;
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
            m_fc  = 0;
            m_ovf = 0;
        end else begin
            if (in_valid && full_m) m_ovf = 1;
            if (pop_m) begin
                void'(q.pop_front());
                m_fc++;
            end
            if (push_m) q.push_back(cur_tag);
        end
        check("model_level", longint'(level), longint'(q.size()));
        check("model_install", longint'(in_stall), longint'(q.size() == DEPTH));
        check("model_overflow", longint'(overflow), longint'(m_ovf));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 1);
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        bit          in_valid;
        bit          out_stall;
        int unsigned tag;
        bit          exp_valid;
        int unsigned exp_level;
        bit          exp_stall;
        bit          exp_ovf;
        int unsigned exp_fc;
        int unsigned exp_tag;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int unsigned next_tag;
        int unsigned delivered;
        int          cyc;

        vecs[0] = '{1, 1, 0, 1, 1, 0, 0, 0, 0};
        vecs[1] = '{0, 1, 0, 1, 1, 0, 0, 0, 0};
        vecs[2] = '{0, 1, 0, 1, 1, 0, 0, 0, 0};
        vecs[3] = '{0, 1, 0, 1, 1, 0, 0, 0, 0};
        vecs[4] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        vecs[5] = '{1, 0, 1, 1, 1, 0, 0, 1, 1};
        vecs[6] = '{1, 0, 2, 1, 1, 0, 0, 2, 2};
        vecs[7] = '{0, 0, 0, 0, 0, 0, 0, 3, 0};

        reset = 1'b1;
        drive(0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_valid", longint'(out_valid), 0);
        check("rst_level", longint'(level), 0);
        check("rst_install", longint'(in_stall), 0);
        check("rst_overflow", longint'(overflow), 0);
        check("rst_fc", frame_count, 0);

        // Single-cycle vectors: push, stall hold, pop, and push/pop through an empty buffer.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].in_valid, vecs[i].tag, vecs[i].out_stall);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), longint'(out_valid), longint'(vecs[i].exp_valid));
            check($sformatf("vec%0d_level", i), longint'(level), longint'(vecs[i].exp_level));
            check($sformatf("vec%0d_install", i), longint'(in_stall), longint'(vecs[i].exp_stall));
            check($sformatf("vec%0d_overflow", i), longint'(overflow), longint'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_fc", i), frame_count, longint'(vecs[i].exp_fc));
            if (vecs[i].exp_valid)
                check_data($sformatf("vec%0d_data", i), out_rvvi, vecs[i].exp_tag);
        end

        // Fill to full, overflow, refused push on pop-from-full, then drain.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, 100 + i, 1);
            tick();
        end
        check("fill_level", longint'(level), 16);
        check("fill_install", longint'(in_stall), 1);
        check("fill_overflow_clear", longint'(overflow), 0);
        drive(1, 999, 1);
        tick();
        check("drop_overflow", longint'(overflow), 1);
        check("drop_level", longint'(level), 16);
        drive(1, 200, 0);
        tick();
        check("fullpop_level", longint'(level), 15);
        check("fullpop_install", longint'(in_stall), 0);
        drive(1, 201, 1);
        tick();
        check("refill_level", longint'(level), 16);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0);
            tick();
        end
        check("drain_level", longint'(level), 0);
        check("drain_fc", frame_count, 17);
        check("drain_overflow_sticky", longint'(overflow), 1);

        // Steady Level=5 with simultaneous push/pop across pointer wrap.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 300 + i, 1);
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            drive(1, 305 + i, 0);
            tick();
            check("steady_level", longint'(level), 5);
        end
        check("steady_fc", frame_count, 40);

        // Reset while partially full with Overflow set.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1, 400 + i, 1);
            tick();
        end
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0);
            tick();
        end
        check("pre_rst_level", longint'(level), 9);
        check("pre_rst_overflow", longint'(overflow), 1);
        reset = 1'b1;
        drive(0, 0, 1);
        tick();
        reset = 1'b0;
        check("midrst_level", longint'(level), 0);
        check("midrst_valid", longint'(out_valid), 0);
        check("midrst_install", longint'(in_stall), 0);
        check("midrst_overflow", longint'(overflow), 0);
        check("midrst_fc", frame_count, 0);

        // Packetizer-style draining (1 cycle ready, 30 stalled) with a core honouring InStall.
        do_reset();
        next_tag  = 0;
        delivered = 0;
        cyc       = 0;
        while (delivered < 1000 && cyc < 40000) begin
            bit stall;
            bit v;
            stall = (cyc % 31) != 0;
            v     = !in_stall && (next_tag < 1000) && ($urandom_range(0, 1) == 1);
            drive(v, next_tag, stall);
            if (v) next_tag++;
            if (q.size() > 0 && !stall) delivered++;
            tick();
            cyc++;
        end
        check("pkt_delivered", longint'(delivered), 1000);
        check("pkt_level", longint'(level), 0);
        check("pkt_fc", frame_count, 1000);
        check("pkt_overflow", longint'(overflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rvvi_buffer.md
# rvvi_buffer

First-word-fall-through elastic buffer between the RVVI trace compressor and the Ethernet packetizer. Absorbs the packetizer's long per-frame stall (burst plus inter-packet delay) so the core stalls only when the buffer is full. Stamps each outgoing record with a monotonically increasing frame count. Output handshake matches the packetizer's valid/RVVIStall protocol.

## Interface
Parameters:
- RVVI_WIDTH, 632: width of one compressed RVVI record (XLEN=64, 3 CSR slots).
- DEPTH, 16: number of record entries; power of two, ≥2.
- FRAME_COUNT_WIDTH, 64: width of the frame counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- InRvvi  input  RVVI_WIDTH  record from compressor.
- InValid  input  1  InRvvi holds a valid record this cycle.
- InStall  output  1  buffer full; core must hold retirement.
- OutRvvi  output  RVVI_WIDTH  head record (fall-through).
- OutValid  output  1  head record present.
- OutStall  input  1  packetizer RVVIStall; low = packetizer samples this cycle.
- FrameCount  output  FRAME_COUNT_WIDTH  count attached to the head record.
- Level  output  $clog2(DEPTH)+1  current occupancy.
- Overflow  output  1  sticky: a record was offered while full.

## Operation
- Storage: DEPTH-entry register array, write pointer WrPtr and read pointer RdPtr, each $clog2(DEPTH)+1 bits (extra wrap bit). Level = WrPtr − RdPtr (modulo 2^($clog2(DEPTH)+1)).
- Full = (Level == DEPTH); Empty = (Level == 0). InStall = Full; OutValid = ~Empty.
- Push = InValid & ~Full: writes InRvvi to mem[WrPtr[low bits]], WrPtr += 1.
- Pop = OutValid & ~OutStall: RdPtr += 1; FrameCount += 1 (wraps at 2^FRAME_COUNT_WIDTH to 0).
- OutRvvi = mem[RdPtr[low bits]] combinationally; value undefined-but-stable when Empty (packetizer ignores it).
- FrameCount is the number of pops since reset; the record at the head always carries the pre-increment value, so the first record after reset is stamped 0.
- Drop: InValid & Full → record discarded, pointers unchanged, Overflow set to 1; Overflow cleared only by reset.
- No bypass: a record pushed into an empty buffer is not visible on OutValid until the next cycle.
- Simultaneous Push and Pop: both pointers advance; Level unchanged. Legal at any Level 1..DEPTH−1. At Level==DEPTH push is refused even if Pop in the same cycle (InStall is pure function of current Level). At Level==0 pop cannot occur.

## Timing
- Reset values: WrPtr=0, RdPtr=0, FrameCount=0, Overflow=0 → OutValid=0, InStall=0, Level=0. Contents discarded; reset mid-frame drops all buffered records.
- Push-to-OutValid latency: 1 cycle. Pop-to-next-head: OutRvvi/FrameCount update in the cycle after Pop.
- InStall rises the cycle after the push that fills the buffer; falls the cycle after the first pop from full.
- Level and Overflow are registered-derived; no combinational path from InValid to InStall, nor from OutStall to OutValid. OutStall → pointer update only.
- Pointer wrap: low bits wrap at DEPTH; wrap bit distinguishes full from empty.

## Test plan
- Reset then single push of record 0xA5.. with OutStall=1 for 3 cycles → OutValid=1 from cycle after push, Level=1, FrameCount=0; drop OutStall → pop, OutValid=0 next cycle, FrameCount=1.
- OutStall=1, push 16 records back-to-back → Level=16, InStall=1 after 16th push; 17th InValid → Overflow=1, Level stays 16; release OutStall → records 0..15 emerge in order with FrameCount 0..15.
- Level=5, InValid=1 and OutStall=0 every cycle for 40 cycles → Level stays 5, output order intact across pointer wrap, FrameCount advances 40.
- Full buffer with InValid=1 and pop in same cycle → push refused, Level 16→15, Overflow=1; next cycle push accepted, Level=16.
- Reset asserted with Level=9 and Overflow=1 → next cycle Level=0, OutValid=0, InStall=0, Overflow=0, FrameCount=0.
- Packetizer-style OutStall (low 1 cycle, high 30 cycles, repeat) with random InValid, 1000 records → every record delivered exactly once, in order, FrameCount contiguous, no Overflow when core honours InStall.
